// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: byte width, default buffer
// depth and the pacing FSM state encoding.
package uart_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GUARD = 2'd2,
        ST_WAIT  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo_8.sv
// Byte-wide synchronous FIFO with a separately tracked occupancy count and a
// single-cycle flush that drops every queued byte.
module sync_fifo_8
    import uart_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [BYTE_W-1:0] head_data,
    output logic [AW:0]       level,
    output logic              full,
    output logic              empty
);

    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [BYTE_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       level_r;
    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;

    assign full_s  = (level_r == DEPTH_L);
    assign empty_s = (level_r == '0);
    // Flush blocks both directions so the pointer snap below stays coherent.
    assign push_s  = push & ~full_s & ~flush;
    assign pop_s   = pop & ~empty_s & ~flush;

    // Storage write port; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else if (flush) begin
            rd_ptr_r <= wr_ptr_r;
            level_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + (AW + 1)'(1);
                2'b01:   level_r <= level_r - (AW + 1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign level     = level_r;
    assign full      = full_s;
    assign empty     = empty_s;

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer ahead of uart_top: queues producer bytes and feeds them to
// the transmitter as single-cycle wr_en strobes paced by tx_busy.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    input  logic              flush,
    output logic [AW:0]       level,
    output logic              wr_en,
    output logic [BYTE_W-1:0] wr_data,
    input  logic              tx_busy
);

    tx_state_e         state_r;
    tx_state_e         state_nxt_s;
    logic              wr_en_r;
    logic              wr_en_nxt_s;
    logic [BYTE_W-1:0] wr_data_r;
    logic              pop_s;
    logic              push_s;
    logic              full_s;
    logic              empty_s;
    logic [BYTE_W-1:0] head_s;
    logic [AW:0]       level_s;

    assign in_ready = ~full_s & ~flush;
    assign push_s   = in_valid & in_ready;

    sync_fifo_8 #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (in_data),
        .pop       (pop_s),
        .flush     (flush),
        .head_data (head_s),
        .level     (level_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Pacing decisions; GUARD masks tx_busy while uart_top is still raising it.
    always_comb begin
        state_nxt_s = state_r;
        wr_en_nxt_s = 1'b0;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s && !tx_busy && !flush) begin
                    pop_s       = 1'b1;
                    wr_en_nxt_s = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_GUARD;
            ST_GUARD: state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (tx_busy) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register plus the registered write strobe and byte to uart_top.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            wr_en_r   <= 1'b0;
            wr_data_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            wr_en_r <= wr_en_nxt_s;
            if (pop_s) begin
                wr_data_r <= head_s;
            end else begin
                wr_data_r <= wr_data_r;
            end
        end
    end

    assign level   = level_s;
    assign wr_en   = wr_en_r;
    assign wr_data = wr_data_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued as expected
// output and a negedge monitor checks every wr_en strobe against the queue.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       flush;
    logic [4:0] level;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_busy;
    logic       force_busy;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];
    int         busy_cnt = 0;
    bit         prev_wr = 1'b0;

    uart_tx_fifo #(.DEPTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .flush    (flush),
        .level    (level),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    // uart_top stand-in: busy rises the cycle after wr_en and lasts 10 cycles
    assign tx_busy = force_busy | (busy_cnt != 0);
    always @(posedge clk) begin
        if (wr_en) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // monitor: every strobe must match the head of the scoreboard queue
    always @(negedge clk) begin
        if (wr_en) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_wr: got wr_data 0x%0h expected no strobe at %0t", wr_data, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (wr_data !== e) begin
                    n_err++;
                    $display("FAIL wr_data: got 0x%0h expected 0x%0h at %0t", wr_data, e, $time);
                end
            end
            if (prev_wr) begin
                n_err++;
                $display("FAIL adjacent_wr: got wr_en on consecutive cycles expected gap at %0t", $time);
            end
        end
        prev_wr = wr_en;
    end

    // call at a negedge; returns at the negedge after the accepting edge
    task automatic push(input logic [7:0] b);
        int t;
        in_valid = 1'b1;
        in_data  = b;
        #1;
        t = 0;
        while (!in_ready && t < 400) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (in_ready) begin
            exp_q.push_back(b);
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL push_timeout: got in_ready 0 expected 1 for byte 0x%0h", b);
        end
        @(negedge clk);
    endtask

    task automatic wait_wr(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wr_en && n < 100);
        if (!wr_en) begin
            n_vec++;
            n_err++;
            $display("FAIL wr_timeout: got no wr_en expected one within 100 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int cnt;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        flush      = 1'b0;
        force_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_level", 32'(level), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // single byte: level 1, then strobe with level back to 0
        push(8'hA5);
        in_valid = 1'b0;
        check("t1_level_1", 32'(level), 32'd1);
        @(negedge clk);
        check("t1_level_0", 32'(level), 32'd0);
        check("t1_wr_en", 32'(wr_en), 32'd1);
        check("t1_wr_data", 32'(wr_data), 32'hA5);
        @(negedge clk);
        check("t1_wr_en_drop", 32'(wr_en), 32'd0);
        repeat (15) @(negedge clk);

        // burst to full with the transmitter held busy
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(i));
        check("t2_level_full", 32'(level), 32'd16);
        in_valid = 1'b1;
        in_data  = 8'h10;
        #1;
        check("t2_in_ready_full", 32'(in_ready), 32'd0);
        @(negedge clk);
        #1;
        check("t2_in_ready_held", 32'(in_ready), 32'd0);
        check("t2_level_held", 32'(level), 32'd16);
        force_busy = 1'b0;
        push(8'h10);
        in_valid = 1'b0;
        wait_wr(n);
        for (int k = 0; k < 3; k++) begin
            wait_wr(n);
            check("t2_pace", 32'(n), 32'd13);
        end
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        repeat (15) @(negedge clk);
        check("t2_drained", 32'(exp_q.size()), 32'd0);
        check("t2_level_0", 32'(level), 32'd0);

        // flush discards queue and the coincident push
        force_busy = 1'b1;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        check("t3_level_3", 32'(level), 32'd3);
        flush   = 1'b1;
        in_data = 8'h44;
        #1;
        check("t3_in_ready_flush", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("t3_level_flushed", 32'(level), 32'd0);

        // flush coinciding with the IDLE pop decision wins
        push(8'h77);
        in_valid = 1'b0;
        check("t3b_level_1", 32'(level), 32'd1);
        flush      = 1'b1;
        force_busy = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        exp_q.delete();
        check("t3b_level_0", 32'(level), 32'd0);
        check("t3b_wr_en", 32'(wr_en), 32'd0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (wr_en) cnt++;
        end
        check("t3_no_wr_after_flush", 32'(cnt), 32'd0);

        // reset mid-stream while one byte is in flight
        push(8'h61);
        push(8'h62);
        push(8'h63);
        push(8'h64);
        push(8'h65);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_level_4", 32'(level), 32'd4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("t4_level_rst", 32'(level), 32'd0);
        check("t4_wr_en_rst", 32'(wr_en), 32'd0);
        check("t4_in_ready_rst", 32'(in_ready), 32'd1);
        check("t4_wr_data_rst", 32'(wr_data), 32'd0);
        push(8'h5A);
        in_valid = 1'b0;
        wait_wr(n);
        check("t4_first_after_rst", 32'(wr_data), 32'h5A);

        repeat (20) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
